// File: rtl/rr_encoder_arbiter_if.sv
// Request/grant bundle between requesters and the round-robin encoder arbiter.
// The arbiter side uses the slave modport; the requester side uses the master modport.
interface rr_encoder_arbiter_if #(
  parameter int unsigned IDX_W = 3
);
  localparam int unsigned N = 1 << IDX_W;

  logic [N-1:0]     req;
  logic [N-1:0]     grant;
  logic [IDX_W-1:0] grant_idx;
  logic             grant_valid;
  logic             timeout;

  modport master (
    output req,
    input  grant, grant_idx, grant_valid, timeout
  );

  modport slave (
    input  req,
    output grant, grant_idx, grant_valid, timeout
  );
endinterface

// File: rtl/rr_encoder_arbiter.sv
// Non-preemptive round-robin arbiter over 2**IDX_W requesters with a binary-encoded grant index.
// Optional forced release after MAX_HOLD cycles is enabled by defining ARB_TIMEOUT_EN.
module rr_encoder_arbiter #(
  parameter int unsigned IDX_W    = 3,
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  rr_encoder_arbiter_if.slave  bus
);
  localparam int unsigned N = 1 << IDX_W;

  typedef enum logic {IDLE, GRANT} state_t;

  if (MAX_HOLD < 2) begin : g_bad_max_hold
    $error("rr_encoder_arbiter: MAX_HOLD must be at least 2");
  end

  state_t           state, state_nxt;
  logic [N-1:0]     grant, grant_nxt;
  logic [IDX_W-1:0] grant_idx, grant_idx_nxt;
  logic             grant_valid, grant_valid_nxt;
  logic [IDX_W-1:0] ptr, ptr_nxt;

  logic [IDX_W-1:0] arb_base;
  logic [N-1:0]     arb_req;
  logic             win_found;
  logic [IDX_W-1:0] win_idx;
  logic             owner_req;
  logic             force_rel;
  logic             release_now;

  assign owner_req = bus.req[grant_idx];

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(MAX_HOLD) + 1;

  logic [CNT_W-1:0] hold_cnt, hold_cnt_nxt;
  logic             timeout, timeout_nxt;

  assign force_rel = (state == GRANT) && owner_req && (hold_cnt == CNT_W'(MAX_HOLD - 1));

  // Counts cycles the current owner has held the grant; cleared on every new grant.
  always_comb begin
    hold_cnt_nxt = '0;
    timeout_nxt  = force_rel;
    if (state == GRANT && !release_now) begin
      hold_cnt_nxt = (hold_cnt == {CNT_W{1'b1}}) ? hold_cnt : CNT_W'(hold_cnt + 1'b1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_cnt <= '0;
      timeout  <= 1'b0;
    end else begin
      hold_cnt <= hold_cnt_nxt;
      timeout  <= timeout_nxt;
    end
  end

  assign bus.timeout = timeout;
`else
  assign force_rel   = 1'b0;
  assign bus.timeout = 1'b0;
`endif

  assign release_now = (state == GRANT) && (!owner_req || force_rel);

  // On release the search starts just past the owner; a forced release also masks the owner.
  assign arb_base = (state == GRANT) ? IDX_W'(grant_idx + 1'b1) : ptr;
  assign arb_req  = force_rel ? (bus.req & ~grant) : bus.req;

  // Circular priority search from arb_base; descending loop lets the nearest request win.
  always_comb begin
    win_idx   = '0;
    win_found = |arb_req;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (arb_req[IDX_W'(arb_base + IDX_W'(i))]) begin
        win_idx = IDX_W'(arb_base + IDX_W'(i));
      end
    end
  end

  always_comb begin
    state_nxt       = state;
    grant_nxt       = grant;
    grant_idx_nxt   = grant_idx;
    grant_valid_nxt = grant_valid;
    ptr_nxt         = ptr;
    case (state)
      IDLE: begin
        if (win_found) begin
          state_nxt       = GRANT;
          grant_nxt       = N'(1) << win_idx;
          grant_idx_nxt   = win_idx;
          grant_valid_nxt = 1'b1;
        end
      end
      GRANT: begin
        if (release_now) begin
          ptr_nxt = IDX_W'(grant_idx + 1'b1);
          if (win_found) begin
            grant_nxt       = N'(1) << win_idx;
            grant_idx_nxt   = win_idx;
            grant_valid_nxt = 1'b1;
          end else begin
            state_nxt       = IDLE;
            grant_nxt       = '0;
            grant_idx_nxt   = '0;
            grant_valid_nxt = 1'b0;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      grant       <= '0;
      grant_idx   <= '0;
      grant_valid <= 1'b0;
      ptr         <= '0;
    end else begin
      state       <= state_nxt;
      grant       <= grant_nxt;
      grant_idx   <= grant_idx_nxt;
      grant_valid <= grant_valid_nxt;
      ptr         <= ptr_nxt;
    end
  end

  assign bus.grant       = grant;
  assign bus.grant_idx   = grant_idx;
  assign bus.grant_valid = grant_valid;
endmodule
